sram1024x18_port_ctrl: RTL
==========================

SRAM1024X18_PORT_CTRL -- requirements
Module: sram1024x18_port_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill all 1024 words after reset.
REQ-002 SHALL have parameter CLEAR_VALUE [17:0], default 18'h0, meaning the data written during clear.
REQ-003 SHALL use one clock and a synchronous active-high reset: clk  in  1  sole clock, all state updates on posedge.
REQ-004 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have: req_valid  in  1  request present.
REQ-006 SHALL have: req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have: req_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have: req_addr  in  10  word address.
REQ-009 SHALL have: req_wdata  in  18  write data.
REQ-010 SHALL have: req_be  in  18  per-bit write enable, 1 = write the bit.
REQ-011 SHALL have: rsp_valid  out  1  read data available.
REQ-012 SHALL have: rsp_ready  in  1  read data consumed when rsp_valid and rsp_ready are both high.
REQ-013 SHALL have: rsp_rdata  out  18  read data.
REQ-014 SHALL have: sram_cen  out  1  active-low chip enable to the SRAM port.
REQ-015 SHALL have: sram_wen  out  1  active-low write enable.
REQ-016 SHALL have: sram_addr  out  10  SRAM address.
REQ-017 SHALL have: sram_wmsk  out  18  SRAM write mask, 1 = keep bit.
REQ-018 SHALL have: sram_wdata  out  18  SRAM write data.
REQ-019 SHALL have: sram_rdata  in  18  SRAM read data.
REQ-020 SHALL have: busy  out  1  clear sequence in progress.

Function
REQ-021 SHALL run a two-state FSM: CLEAR and RUN; after reset it enters CLEAR when CLEAR_ON_RESET=1, otherwise RUN.
REQ-022 In CLEAR, SHALL use a 10-bit counter to issue one write per cycle to addresses 0..1023 in order, with sram_wmsk=0 and sram_wdata=CLEAR_VALUE; req_ready=0 and busy=1 throughout.
REQ-023 CLEAR SHALL issue exactly 1024 writes; the FSM SHALL move to RUN on the cycle after the address-1023 write is registered, and busy SHALL fall in that cycle.
REQ-024 All sram_* outputs SHALL be registered; a request accepted in cycle N SHALL drive the SRAM in cycle N+1.
REQ-025 When no request is issued, sram_cen=1 and sram_wen=1; addr, wdata and wmsk SHALL hold their last values.
REQ-026 An accepted write SHALL drive sram_cen=0, sram_wen=0, sram_addr=req_addr, sram_wdata=req_wdata and sram_wmsk=~req_be; writes SHALL produce no response.
REQ-027 An accepted read SHALL drive sram_cen=0 and sram_wen=1; sram_rdata SHALL be sampled at the end of cycle N+2 into a 4-entry response FIFO, so rsp_valid rises no earlier than cycle N+3.
REQ-028 SHALL track in-flight reads in a 2-stage valid pipeline; req_ready = RUN && (fifo_count + inflight_reads < 4), independent of req_we and req_valid.
REQ-029 The response FIFO SHALL never overflow; responses SHALL be returned in issue order.
REQ-030 A FIFO push and pop in the same cycle SHALL leave the count unchanged; rsp_rdata SHALL be the FIFO head and hold stable while rsp_valid=1 and rsp_ready=0.
REQ-031 A read issued the cycle after a write to the same address SHALL return the newly written bits (program-order consistency).
REQ-032 With rsp_ready held high, SHALL sustain one accepted request per cycle.

Reset
REQ-033 While rst=1 the block SHALL drive: sram_cen=1, sram_wen=1, sram_addr=0, sram_wmsk=18'h3FFFF, sram_wdata=0, rsp_valid=0, req_ready=0, and busy=CLEAR_ON_RESET.
REQ-034 Reset SHALL empty the FIFO, discard in-flight reads, and zero the clear counter; a reset during CLEAR SHALL restart the clear at address 0.

Verification
REQ-035 The bench SHALL check: reset with CLEAR_ON_RESET=1 -> 1024 consecutive writes at addresses 0..1023, busy low from cycle 1025, then a read of 10'h3FF returns 18'h0.
REQ-036 The bench SHALL check: write addr 5, data 18'h2AAAA, be 18'h3FFFF, then read addr 5 the next cycle -> rsp_rdata=18'h2AAAA, with rsp_valid exactly 3 cycles after the read acceptance.
REQ-037 The bench SHALL check: with memory at 18'h3FFFF, write data 0 with be=18'h000FF -> a read returns 18'h3FF00.
REQ-038 The bench SHALL check: rsp_ready=0 while reading addresses 1..6 back-to-back -> exactly 4 reads accepted, then req_ready=0; after rsp_ready=1, data returns in order 1,2,3,4.
REQ-039 The bench SHALL check: rst asserted at clear address 512 -> restart at 0, and a full 1024-write clear completes.
REQ-040 The bench SHALL check: rst asserted with 2 reads in flight and 2 FIFO entries held -> rsp_valid=0 after reset and no stale responses appear.

Source files
------------

// File: rtl/sram1024x18_port_ctrl.sv
// Port controller for a 1024x18 single-port synchronous SRAM: optional clear after reset,
// registered SRAM drive, 2-cycle read pipeline and a 4-entry in-order response FIFO.
module sram1024x18_port_ctrl #(
    parameter int          CLEAR_ON_RESET = 1,
    parameter logic [17:0] CLEAR_VALUE    = 18'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [9:0]  req_addr,
    input  logic [17:0] req_wdata,
    input  logic [17:0] req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [17:0] rsp_rdata,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [9:0]  sram_addr,
    output logic [17:0] sram_wmsk,
    output logic [17:0] sram_wdata,
    input  logic [17:0] sram_rdata,
    output logic        busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  clr_cnt;
    logic        clr_last;
    logic        clr_issue;
    logic        rd_p1;
    logic        rd_p2;
    logic [17:0] fifo_mem [4];
    logic [1:0]  fifo_wr_ptr;
    logic [1:0]  fifo_rd_ptr;
    logic [2:0]  fifo_count;
    logic [3:0]  occupancy;
    logic        accept;
    logic        fifo_push;
    logic        fifo_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) state <= ST_CLEAR;
            else                     state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // clr_last marks that address 1023 has been issued; one idle CLEAR cycle follows it
    always_comb begin
        state_nxt = state;
        clr_issue = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clr_last) state_nxt = ST_RUN;
                else          clr_issue = 1'b1;
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = state;
        endcase
    end

    // Reads accepted but not yet popped can never exceed the FIFO depth, so it cannot overflow
    assign occupancy = {1'b0, fifo_count} + {3'b000, rd_p1} + {3'b000, rd_p2};
    assign req_ready = !rst && (state == ST_RUN) && (occupancy < 4'd4);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = !rst && (fifo_count != 3'd0);
    assign busy      = rst ? (CLEAR_ON_RESET != 0) : (state == ST_CLEAR);
    assign rsp_rdata = fifo_mem[fifo_rd_ptr];
    assign fifo_push = rd_p2;
    assign fifo_pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_cen   <= 1'b1;
            sram_wen   <= 1'b1;
            sram_addr  <= 10'd0;
            sram_wmsk  <= 18'h3FFFF;
            sram_wdata <= 18'h0;
            clr_cnt    <= 10'd0;
            clr_last   <= 1'b0;
        end else begin
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            if (clr_issue) begin
                sram_cen   <= 1'b0;
                sram_wen   <= 1'b0;
                sram_addr  <= clr_cnt;
                sram_wmsk  <= 18'h0;
                sram_wdata <= CLEAR_VALUE;
                clr_cnt    <= clr_cnt + 10'd1;
                clr_last   <= (clr_cnt == 10'h3FF);
            end else if (accept) begin
                sram_cen  <= 1'b0;
                sram_wen  <= !req_we;
                sram_addr <= req_addr;
                if (req_we) begin
                    sram_wmsk  <= ~req_be;
                    sram_wdata <= req_wdata;
                end
            end
        end
    end

    // rd_p1: read on the SRAM pins; rd_p2: SRAM read data valid and captured at the end of this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_p1 <= 1'b0;
            rd_p2 <= 1'b0;
        end else begin
            rd_p1 <= accept && !req_we;
            rd_p2 <= rd_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr <= 2'd0;
            fifo_rd_ptr <= 2'd0;
            fifo_count  <= 3'd0;
        end else begin
            if (fifo_push) fifo_wr_ptr <= fifo_wr_ptr + 2'd1;
            if (fifo_pop)  fifo_rd_ptr <= fifo_rd_ptr + 2'd1;
            if (fifo_push && !fifo_pop)      fifo_count <= fifo_count + 3'd1;
            else if (!fifo_push && fifo_pop) fifo_count <= fifo_count - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[fifo_wr_ptr] <= sram_rdata;
    end

endmodule
